// File: rtl/circuit_evaluator_if.sv
// Result stream of the circuit evaluator.
//   master : drives res_valid plus the per-vector result fields, samples res_ready
//   slave  : consumes results and drives res_ready
// A result transfers on a clk edge where res_valid && res_ready.
interface circuit_evaluator_if #(
  parameter int IN_WIDTH = 2,
  parameter int CW       = 7
);
  logic                res_valid;
  logic                res_ready;
  logic [IN_WIDTH-1:0] res_vector;
  logic [CW-1:0]       res_ones;
  logic [CW-1:0]       res_toggles;
  logic                res_value;
  logic                res_unstable;

  modport master (
    output res_valid, res_vector, res_ones, res_toggles, res_value, res_unstable,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_vector, res_ones, res_toggles, res_value, res_unstable,
    output res_ready
  );
endinterface

// File: rtl/circuit_evaluator.sv
// Stimulus/response harness for small evolved circuits.
// Walks every input vector in ascending order. Each vector is applied, left to
// settle, and the circuit output is then sampled over a fixed window. Each
// vector is classified as stable-0, stable-1 or unstable, and its result is
// streamed over a valid/ready handshake. The full truth table and the
// instability map are assembled along the way.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   start          one-cycle evaluation request (ignored while busy)
//   busy, done     run in progress / one-cycle completion pulse
//   dut_in         registered stimulus to the circuit under test
//   dut_out        circuit output, asynchronous to clk
//   truth_table    bit k = stable-1 result of vector k
//   unstable_map   bit k = unstable result of vector k
//   res            per-vector result stream (master side)
module circuit_evaluator #(
  parameter int  IN_WIDTH      = 2,
  parameter int  SETTLE_CYCLES = 16,
  parameter int  SAMPLE_CYCLES = 64,
  localparam int CW            = $clog2(SAMPLE_CYCLES + 1),
  localparam int NV            = 1 << IN_WIDTH,
  localparam int MAXC          = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES,
  localparam int CNTW          = $clog2(MAXC + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [IN_WIDTH-1:0] dut_in,
  input  logic                dut_out,
  output logic [NV-1:0]       truth_table,
  output logic [NV-1:0]       unstable_map,
  circuit_evaluator_if.master res
);

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, REPORT, FINISH} state_t;

  state_t              state;
  logic                sync_p0;
  logic                sync_p1;
  logic                prev_p2;
  logic [IN_WIDTH-1:0] vec;
  logic [CNTW-1:0]     cnt;
  logic [CW-1:0]       ones;
  logic [CW-1:0]       toggles;
  logic [CW-1:0]       ones_nxt;
  logic [CW-1:0]       toggles_nxt;

  // Stage p0/p1: two-flop synchronizer for the asynchronous circuit output
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= dut_out;
      sync_p1 <= sync_p0;
    end
  end

  // Accumulator values including the current sample; the first sample of a
  // window (cnt == 0) has no predecessor and cannot count as a toggle.
  always_comb begin
    ones_nxt    = ones + CW'(sync_p1);
    toggles_nxt = toggles;
    if (cnt != '0 && sync_p1 != prev_p2)
      toggles_nxt = toggles + CW'(1);
  end

  // Stage p2: sequencing, sample accumulation and result registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      dut_in           <= '0;
      vec              <= '0;
      cnt              <= '0;
      ones             <= '0;
      toggles          <= '0;
      prev_p2          <= 1'b0;
      truth_table      <= '0;
      unstable_map     <= '0;
      res.res_valid    <= 1'b0;
      res.res_vector   <= '0;
      res.res_ones     <= '0;
      res.res_toggles  <= '0;
      res.res_value    <= 1'b0;
      res.res_unstable <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            truth_table  <= '0;
            unstable_map <= '0;
            vec          <= '0;
            busy         <= 1'b1;
            state        <= APPLY;
          end
        end
        APPLY: begin
          dut_in  <= vec;
          cnt     <= '0;
          ones    <= '0;
          toggles <= '0;
          state   <= SETTLE;
        end
        SETTLE: begin
          if (cnt == CNTW'(SETTLE_CYCLES - 1)) begin
            cnt   <= '0;
            state <= SAMPLE;
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end
        SAMPLE: begin
          ones    <= ones_nxt;
          toggles <= toggles_nxt;
          prev_p2 <= sync_p1;
          if (cnt == CNTW'(SAMPLE_CYCLES - 1)) begin
            cnt              <= '0;
            res.res_valid    <= 1'b1;
            res.res_vector   <= vec;
            res.res_ones     <= ones_nxt;
            res.res_toggles  <= toggles_nxt;
            res.res_value    <= (ones_nxt == CW'(SAMPLE_CYCLES));
            res.res_unstable <= (ones_nxt != '0 && ones_nxt != CW'(SAMPLE_CYCLES)) ||
                                (toggles_nxt != '0);
            state            <= REPORT;
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end
        REPORT: begin
          // Stalls here under back-pressure: dut_in holds and nothing is sampled.
          if (res.res_ready) begin
            res.res_valid     <= 1'b0;
            truth_table[vec]  <= res.res_value;
            unstable_map[vec] <= res.res_unstable;
            if (&vec) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= FINISH;
            end else begin
              vec   <= vec + IN_WIDTH'(1);
              state <= APPLY;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_circuit_evaluator.sv
// Bench for circuit_evaluator: two instances (default timing, and a minimal
// 2/2 settle/sample variant), a behavioural circuit model driven by a
// per-vector mode table (0 = constant 0, 1 = constant 1, 2 = toggle every
// clock) and a per-cycle checker that compares every result, the done
// timing and the final maps against expectations derived from the modes.
module tb_circuit_evaluator;
  localparam int N_A   = 64;
  localparam int CW_A  = 7;
  localparam int LAT_A = 329;
  localparam int N_B   = 2;
  localparam int CW_B  = 2;
  localparam int LAT_B = 25;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic       busy_a, done_a, busy_b, done_b;
  logic [1:0] dut_in_a, dut_in_b;
  logic       dut_out_a = 1'b0;
  logic       dut_out_b = 1'b1;
  logic [3:0] tt_a, um_a, tt_b, um_b;
  logic       rdy_a = 1'b1;

  circuit_evaluator_if #(.IN_WIDTH(2), .CW(CW_A)) ifa ();
  circuit_evaluator_if #(.IN_WIDTH(2), .CW(CW_B)) ifb ();

  assign ifa.res_ready = rdy_a;
  assign ifb.res_ready = 1'b1;

  circuit_evaluator u_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .busy(busy_a), .done(done_a),
    .dut_in(dut_in_a), .dut_out(dut_out_a), .truth_table(tt_a), .unstable_map(um_a),
    .res(ifa.master)
  );

  circuit_evaluator #(.IN_WIDTH(2), .SETTLE_CYCLES(2), .SAMPLE_CYCLES(N_B)) u_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .busy(busy_b), .done(done_b),
    .dut_in(dut_in_b), .dut_out(dut_out_b), .truth_table(tt_b), .unstable_map(um_b),
    .res(ifb.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus-side controls (written by the sequencer only)
  int mode [4];
  int rdy_mode = 0;
  int test_id  = 0;
  int tmo_req  = 0;

  // Behavioural circuit under test
  logic tg = 1'b0;
  always @(negedge clk) begin
    tg = ~tg;
    case (mode[dut_in_a])
      0:       dut_out_a = 1'b0;
      1:       dut_out_a = 1'b1;
      default: dut_out_a = tg;
    endcase
  end

  // Consumer ready: always, random, or 10-cycle hold at the vector-1 result
  int held = 0;
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 2) begin
      if (ifa.res_valid && ifa.res_vector == 2'd1 && held < 10) begin
        rdy_a = 1'b0;
        held++;
      end else begin
        rdy_a = 1'b1;
      end
    end else begin
      held  = 0;
      rdy_a = (rdy_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Reference model from the classification rules
  function automatic int m_ones(input int m, input int n);
    return (m == 0) ? 0 : ((m == 1) ? n : n / 2);
  endfunction
  function automatic int m_tog(input int m, input int n);
    return (m == 2) ? n - 1 : 0;
  endfunction
  function automatic int m_val(input int m, input int n);
    return (m_ones(m, n) == n) ? 1 : 0;
  endfunction
  function automatic int m_uns(input int m, input int n);
    int o;
    o = m_ones(m, n);
    return ((o > 0 && o < n) || m_tog(m, n) != 0) ? 1 : 0;
  endfunction

  // Checker state (written by the checker only)
  int n_cmp = 0, n_bad = 0, tmo_seen = 0;
  bit pend_rst = 0, in_run_a = 0, in_run_b = 0, hold_prev = 0;
  int rs_a, rs_b, hs_a, hs_b, nv_a, nv_b, stalls_a, quiet = 0;
  int got_ones [4], got_tog [4], got_uns [4];
  logic [1:0] sv_vec;
  logic [CW_A-1:0] sv_ones, sv_tog;
  logic sv_val, sv_uns;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] ett, eum;
    int m;
    if (tmo_req != tmo_seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_done: got no done pulse, expected done within budget (cycle %0d)", cyc);
      tmo_seen = tmo_req;
    end
    if (pend_rst) begin
      chk("rst_dut_in", dut_in_a, 0);          chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);              chk("rst_valid", ifa.res_valid, 0);
      chk("rst_vector", ifa.res_vector, 0);    chk("rst_ones", ifa.res_ones, 0);
      chk("rst_toggles", ifa.res_toggles, 0);  chk("rst_value", ifa.res_value, 0);
      chk("rst_unstable", ifa.res_unstable, 0); chk("rst_tt", tt_a, 0);
      chk("rst_um", um_a, 0);                  chk("rst_b_busy", busy_b, 0);
      chk("rst_b_valid", ifb.res_valid, 0);    chk("rst_b_dut_in", dut_in_b, 0);
    end
    pend_rst = !reset_n;
    if (!reset_n) begin
      in_run_a = 0; in_run_b = 0; quiet = 0; hold_prev = 0;
    end else begin
      // ---- instance A ----
      if (quiet > 0) begin
        chk("no_restart_busy", busy_a, 0);
        quiet--;
      end
      if (busy_a && !in_run_a) begin
        in_run_a = 1; rs_a = cyc - 1; hs_a = 0; nv_a = 0; stalls_a = 0; hold_prev = 0;
      end
      if (ifa.res_valid) begin
        chk("valid_in_run", in_run_a, 1);
        if (hold_prev) begin
          chk("hold_vector", ifa.res_vector, sv_vec);  chk("hold_ones", ifa.res_ones, sv_ones);
          chk("hold_toggles", ifa.res_toggles, sv_tog); chk("hold_value", ifa.res_value, sv_val);
          chk("hold_unstable", ifa.res_unstable, sv_uns);
        end
        m = mode[ifa.res_vector];
        chk("res_vector", ifa.res_vector, nv_a);
        chk("dut_in_hold", dut_in_a, ifa.res_vector);
        chk("res_ones", ifa.res_ones, m_ones(m, N_A));
        chk("res_toggles", ifa.res_toggles, m_tog(m, N_A));
        chk("res_value", ifa.res_value, m_val(m, N_A));
        chk("res_unstable", ifa.res_unstable, m_uns(m, N_A));
        if (rdy_a) begin
          got_ones[ifa.res_vector] = int'(ifa.res_ones);
          got_tog[ifa.res_vector]  = int'(ifa.res_toggles);
          got_uns[ifa.res_vector]  = int'(ifa.res_unstable);
          hs_a++; nv_a++; hold_prev = 0;
        end else begin
          stalls_a++; hold_prev = 1;
          sv_vec = ifa.res_vector; sv_ones = ifa.res_ones; sv_tog = ifa.res_toggles;
          sv_val = ifa.res_value;  sv_uns = ifa.res_unstable;
        end
      end
      if (done_a) begin
        ett = '0; eum = '0;
        for (int k = 0; k < 4; k++) begin
          ett[k] = (m_val(mode[k], N_A) != 0);
          eum[k] = (m_uns(mode[k], N_A) != 0);
        end
        chk("done_in_run", in_run_a, 1);
        chk("done_cycle", cyc, rs_a + LAT_A + stalls_a);
        chk("handshakes", hs_a, 4);
        chk("busy_at_done", busy_a, 0);
        chk("truth_table", tt_a, ett);
        chk("unstable_map", um_a, eum);
        if (test_id == 1) begin
          chk("xor_latency", cyc - rs_a, 329); chk("xor_tt", tt_a, 4'b0110);
          chk("xor_um", um_a, 4'b0000);        chk("xor_ones0", got_ones[0], 0);
          chk("xor_ones1", got_ones[1], 64);   chk("xor_ones2", got_ones[2], 64);
          chk("xor_ones3", got_ones[3], 0);    chk("xor_tog1", got_tog[1], 0);
        end
        if (test_id == 2) begin
          chk("tog_ones2", got_ones[2], 32);   chk("tog_toggles2", got_tog[2], 63);
          chk("tog_uns2", got_uns[2], 1);      chk("tog_tt", tt_a, 4'b1000);
          chk("tog_um", um_a, 4'b0100);
        end
        if (test_id == 3) chk("hold_latency", cyc - rs_a, 339);
        if (test_id == 4) quiet = 3;
        in_run_a = 0;
      end else if (in_run_a) begin
        chk("busy_in_run", busy_a, 1);
        if (cyc > rs_a + LAT_A + stalls_a) begin
          chk("done_timeout_a", 0, 1);
          in_run_a = 0;
        end
      end
      // ---- instance B ----
      if (busy_b && !in_run_b) begin
        in_run_b = 1; rs_b = cyc - 1; hs_b = 0; nv_b = 0;
      end
      if (ifb.res_valid) begin
        chk("b_vector", ifb.res_vector, nv_b);
        chk("b_ones", ifb.res_ones, m_ones(1, N_B));
        chk("b_toggles", ifb.res_toggles, m_tog(1, N_B));
        chk("b_value", ifb.res_value, 1);
        chk("b_unstable", ifb.res_unstable, 0);
        hs_b++; nv_b++;
      end
      if (done_b) begin
        chk("b_done_in_run", in_run_b, 1);
        chk("b_latency", cyc - rs_b, LAT_B);
        chk("b_handshakes", hs_b, 4);
        chk("b_tt", tt_b, 4'b1111);
        chk("b_um", um_b, 4'b0000);
        in_run_b = 0;
      end else if (in_run_b && cyc > rs_b + LAT_B) begin
        chk("done_timeout_b", 0, 1);
        in_run_b = 0;
      end
    end
  end

  task automatic set_modes(input int m0, input int m1, input int m2, input int m3);
    mode[0] = m0; mode[1] = m1; mode[2] = m2; mode[3] = m3;
  endtask

  // extra != 0: re-pulse start at cycle 50 of the run and in the done cycle
  task automatic run_a(input int extra);
    int k;
    bit seen;
    @(posedge clk); #1;
    start_a = 1'b1; k = cyc;
    @(posedge clk); #1;
    start_a = 1'b0;
    seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(posedge clk); #1;
      start_a = (extra != 0 && cyc == k + 50);
      if (done_a) begin
        seen = 1;
        if (extra != 0) start_a = 1'b1;
      end
    end
    @(posedge clk); #1;
    start_a = 1'b0;
    if (!seen) tmo_req++;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic run_b();
    bit seen;
    @(posedge clk); #1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      if (done_b) seen = 1;
    end
    if (!seen) tmo_req++;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    set_modes(0, 1, 1, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    test_id = 1; set_modes(0, 1, 1, 0); run_a(0);   // XOR
    test_id = 0; run_b();                            // constant 1, 2/2 timing
    test_id = 2; set_modes(0, 0, 2, 1); run_a(0);   // AND, vector 2 toggling
    test_id = 3; set_modes(0, 1, 1, 0); rdy_mode = 2; run_a(0);
    rdy_mode = 0;
    test_id = 4; set_modes(0, 1, 1, 0); run_a(1);   // start re-pulsed mid-run and at done
    test_id = 0; rdy_mode = 1;
    for (int r = 0; r < 3; r++) begin
      set_modes($urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(0, 2), $urandom_range(0, 2));
      run_a(0);
    end
    rdy_mode = 0;

    // Reset pulse while vector 2 is being sampled, then a fresh evaluation
    set_modes(0, 0, 2, 1);
    @(posedge clk); #1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (199) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_id = 2; run_a(0);

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
